uart_rx_fifo: RTL

//  Parametrised MiniUart receiver: oversampled serial RxD -> DATA_BITS-wide words, optional parity

---
 rtl/uart_rx_fifo.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// MiniUart receiver: oversampled rxd is framed into DATA_BITS-wide words with optional parity,
// sticky frame/parity/overrun flags, and a show-ahead receive FIFO read by the CPU bus.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 en_rx,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_valid,
  output logic [AW:0]          fifo_count,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD      = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t                 state;
  logic                   rxd_meta, rxd_s;
  logic [CW-1:0]          cnt;
  logic [3:0]             bits;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bad;
  logic                   push_req;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   do_pop, do_push, ovr_evt;

  // rxd is asynchronous to clk; idle-high reset avoids a false start bit after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rxd_s, rxd_meta} <= 2'b11;
    else        {rxd_s, rxd_meta} <= {rxd_meta, rxd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bits      <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      push_req  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the same
      // block; the last one wins, which makes push_req a pulse and lets a set beat err_clr.
      push_req <= 1'b0;
      if (err_clr) err_frame <= 1'b0;
      if (en_rx) begin
        case (state)
          IDLE: if (!rxd_s) begin
            state   <= START;
            cnt     <= '0;
            bits    <= '0;
            par_bad <= 1'b0;
          end
          START: if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
          DATA: if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            bits  <= bits + 4'd1;
            if (bits == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else cnt <= cnt + 1'b1;
          PARITY: if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_bad <= ((^shreg) ^ rxd_s) ^ ODD;
            state   <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxd_s) begin
              push_req <= 1'b1;
              state    <= IDLE;
            end else begin
              err_frame <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else cnt <= cnt + 1'b1;
          WAIT_IDLE: if (rxd_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A pop frees the slot the same cycle, so push and pop together while full is not an overrun
  assign do_pop  = rd_en && (count != '0);
  assign do_push = push_req && ((count != DEPTH) || do_pop);
  assign ovr_evt = push_req && (count == DEPTH) && !do_pop;

  // NOTE: storage needs no reset; emptiness is tracked by count and d_out is gated by it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (err_clr)             err_parity  <= 1'b0;
      if (push_req && par_bad) err_parity  <= 1'b1;
      if (err_clr)             err_overrun <= 1'b0;
      if (ovr_evt)             err_overrun <= 1'b1;
    end
  end

  assign rx_valid   = (count != '0);
  assign fifo_count = count;
  assign d_out      = rx_valid ? mem[rd_ptr] : '0;

endmodule
